prefix_encode_emitter: RTL

// - Transmit-side counterpart of the decode prefix detector. Takes one instruction descriptor
//   (REP, segment override, operand-size flags, opcode byte) and serialises it as an x86 byte stream.
// - Stream format: up to 3 prefix bytes, then the opcode, one byte per accepted beat.
// - Feeds the fetch/decode byte queue in the self-test stimulus path.
// - Every prefix byte it emits is one the prefix detector recognises.

---
 rtl/prefix_encode_emitter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/prefix_encode_emitter.sv
// ---------------------------------------------------------------------------
// prefix_encode_emitter
//   Serialises one instruction descriptor (REP, segment override, operand
//   size, opcode) into an x86 byte stream: up to three prefix bytes in the
//   fixed order F3, segment, 66, followed by the opcode byte. One byte is
//   sent per accepted output beat; absent prefixes cost no cycles.
//
//   Optional feature macro: PREFIX_ENC_PACKED_EN
//     When defined, adds pkt_valid / pkt_bytes / pkt_count, a packed copy of
//     the prefix window laid out for direct comparison against the decode
//     prefix detector. When undefined, those ports and registers are absent
//     and the byte stream is unchanged.
// ---------------------------------------------------------------------------
module prefix_encode_emitter #(
    // 1: a new descriptor may be accepted in the cycle the opcode beat leaves
    parameter int unsigned BACK_TO_BACK = 1
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rep,
    input  logic [2:0]  req_seg,
    input  logic        req_opsize,
    input  logic [7:0]  req_opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        out_is_pfx,
    output logic        seg_err
`ifdef PREFIX_ENC_PACKED_EN
    ,
    output logic        pkt_valid,
    output logic [23:0] pkt_bytes,
    output logic [1:0]  pkt_count
`endif
);

    // -----------------------------------------------------------------------
    // Types
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REP  = 3'd1,
        S_SEG  = 3'd2,
        S_OPS  = 3'd3,
        S_OPC  = 3'd4
    } state_t;

    typedef struct packed {
        logic       rep;
        logic [2:0] seg;
        logic       opsize;
        logic [7:0] opcode;
    } desc_t;

    localparam logic [7:0] REP_BYTE    = 8'hF3;
    localparam logic [7:0] OPSIZE_BYTE = 8'h66;
    localparam logic [2:0] SEG_NONE    = 3'd0;
    localparam logic [2:0] SEG_RSVD    = 3'd7;

    // -----------------------------------------------------------------------
    // Descriptor helpers
    // -----------------------------------------------------------------------
    // Codes 1..6 carry a real segment; 0 is "none" and 7 is treated as none.
    function automatic logic seg_present(input logic [2:0] seg);
        return (seg != SEG_NONE) && (seg != SEG_RSVD);
    endfunction

    function automatic logic [7:0] seg_byte(input logic [2:0] seg);
        logic [7:0] b;
        case (seg)
            3'd1:    b = 8'h26;  // ES
            3'd2:    b = 8'h2E;  // CS
            3'd3:    b = 8'h36;  // SS
            3'd4:    b = 8'h3E;  // DS
            3'd5:    b = 8'h64;  // FS
            3'd6:    b = 8'h65;  // GS
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // First beat of a freshly accepted descriptor.
    function automatic state_t first_state(input desc_t d);
        if (d.rep)                  return S_REP;
        else if (seg_present(d.seg)) return S_SEG;
        else if (d.opsize)          return S_OPS;
        else                        return S_OPC;
    endfunction

    // Beat following the REP prefix.
    function automatic state_t after_rep(input desc_t d);
        if (seg_present(d.seg)) return S_SEG;
        else if (d.opsize)      return S_OPS;
        else                    return S_OPC;
    endfunction

    // Beat following the segment prefix.
    function automatic state_t after_seg(input desc_t d);
        return d.opsize ? S_OPS : S_OPC;
    endfunction

    // Byte presented while sitting in a given beat state.
    function automatic logic [7:0] beat_byte(input state_t s, input desc_t d);
        logic [7:0] b;
        case (s)
            S_REP:   b = REP_BYTE;
            S_SEG:   b = seg_byte(d.seg);
            S_OPS:   b = OPSIZE_BYTE;
            S_OPC:   b = d.opcode;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef PREFIX_ENC_PACKED_EN
    // Number of prefix bytes the descriptor produces (0..3).
    function automatic logic [1:0] prefix_count(input desc_t d);
        return {1'b0, d.rep} + {1'b0, seg_present(d.seg)} + {1'b0, d.opsize};
    endfunction

    // Prefixes packed left-justified: first prefix in [23:16], unused 00.
    function automatic logic [23:0] pack_prefixes(input desc_t d);
        logic [23:0] acc;
        acc = '0;
        if (d.rep)              acc = {acc[15:0], REP_BYTE};
        if (seg_present(d.seg)) acc = {acc[15:0], seg_byte(d.seg)};
        if (d.opsize)           acc = {acc[15:0], OPSIZE_BYTE};
        case (prefix_count(d))
            2'd1:    acc = acc << 16;
            2'd2:    acc = acc << 8;
            default: acc = acc;
        endcase
        return acc;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    state_t     r_state;
    state_t     w_next_state;
    desc_t      r_desc;
    desc_t      w_req_desc;
    desc_t      w_next_desc;
    logic       w_accept;
    logic [7:0] r_out_byte;
    logic       r_seg_err;

    assign w_req_desc = '{rep:    req_rep,
                          seg:    req_seg,
                          opsize: req_opsize,
                          opcode: req_opcode};

    // Handshake and stream outputs decoded from registered state.
    always_comb begin
        out_valid  = (r_state != S_IDLE);
        out_last   = (r_state == S_OPC);
        out_is_pfx = (r_state == S_REP) || (r_state == S_SEG) || (r_state == S_OPS);
        req_ready  = (r_state == S_IDLE) ||
                     ((BACK_TO_BACK != 0) && (r_state == S_OPC) && out_ready);
        w_accept   = req_valid && req_ready;
        out_byte   = r_out_byte;
        seg_err    = r_seg_err;
    end

    // Next-state logic: advance on an accepted beat, skipping absent prefixes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement leaves it unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next_state = first_state(w_req_desc);
            S_REP:  if (out_ready) w_next_state = after_rep(r_desc);
            S_SEG:  if (out_ready) w_next_state = after_seg(r_desc);
            S_OPS:  if (out_ready) w_next_state = S_OPC;
            S_OPC: begin
                if (out_ready) begin
                    if (w_accept) w_next_state = first_state(w_req_desc);
                    else          w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        // The byte for the next beat comes from the new descriptor on accept.
        w_next_desc = w_accept ? w_req_desc : r_desc;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Descriptor, output byte and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_desc     <= '0;
            r_out_byte <= 8'h00;
            r_seg_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_desc <= w_req_desc;
                if (req_seg == SEG_RSVD) r_seg_err <= 1'b1;
            end
            // Stalls leave state and descriptor unchanged, so this holds.
            r_out_byte <= beat_byte(w_next_state, w_next_desc);
        end
    end

`ifdef PREFIX_ENC_PACKED_EN
    logic [23:0] r_pkt_bytes;
    logic [1:0]  r_pkt_count;
    logic        r_pkt_valid;

    // Packed prefix window, captured on accept; valid pulses with first beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_valid <= 1'b0;
            r_pkt_bytes <= 24'h0;
            r_pkt_count <= 2'd0;
        end else begin
            r_pkt_valid <= w_accept;
            if (w_accept) begin
                r_pkt_bytes <= pack_prefixes(w_req_desc);
                r_pkt_count <= prefix_count(w_req_desc);
            end
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_bytes = r_pkt_bytes;
    assign pkt_count = r_pkt_count;
`endif

endmodule
